// File: rtl/coin_intake.sv
// coin_intake: synchronise, debounce and classify coin/cancel sensors
// into a one-strike coin bus for the vending-machine controller.
module coin_intake #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned RELEASE  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       coin25_raw,
    input  logic       cancel_raw,
    output logic [1:0] coin_code,
    output logic       confirm,
    output logic       reject,
    output logic       busy,
    output logic [7:0] err_count
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        EMIT,
        WAIT_REL
    } state_t;

    localparam logic [7:0] DB = 8'(DEBOUNCE);
    localparam logic [7:0] RL = 8'(RELEASE);

    state_t     state;
    state_t     state_nx;
    logic [3:0] sync1;
    logic [3:0] sv;
    logic [3:0] cand;
    logic [3:0] cand_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic [7:0] cnt_inc;
    logic [1:0] code_nx;
    logic       confirm_nx;
    logic       reject_nx;
    logic [7:0] err_nx;
    logic [1:0] cls_code;
    logic       cls_ok;

    // Two-flop synchronisers; sv = {cancel, c25, c10, c5}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b0000;
            sv    <= 4'b0000;
        end else begin
            sync1 <= {cancel_raw, coin25_raw, coin10_raw, coin5_raw};
            sv    <= sync1;
        end
    end

    // Cancel wins over any coin bits; multiple coins are illegal
    always_comb begin
        cls_code = 2'b00;
        cls_ok   = 1'b0;
        unique case (1'b1)
            cand[3]: begin
                cls_code = 2'b00;
                cls_ok   = 1'b1;
            end
            (cand == 4'b0001): begin
                cls_code = 2'b01;
                cls_ok   = 1'b1;
            end
            (cand == 4'b0010): begin
                cls_code = 2'b10;
                cls_ok   = 1'b1;
            end
            (cand == 4'b0100): begin
                cls_code = 2'b11;
                cls_ok   = 1'b1;
            end
            default: begin
                cls_code = 2'b00;
                cls_ok   = 1'b0;
            end
        endcase
    end

    assign cnt_inc = cnt + 8'd1;

    always_comb begin
        state_nx   = state;
        cand_nx    = cand;
        cnt_nx     = cnt;
        code_nx    = coin_code;
        confirm_nx = 1'b0;
        reject_nx  = 1'b0;
        err_nx     = err_count;
        case (state)
            IDLE: begin
                if (sv != 4'b0000) begin
                    cand_nx  = sv;
                    cnt_nx   = 8'd1;
                    state_nx = (DB == 8'd1) ? EMIT : SETTLE;
                end
            end
            SETTLE: begin
                if (sv == cand) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == DB) begin
                        state_nx = EMIT;
                    end
                end else begin
                    cnt_nx   = 8'd0;
                    state_nx = IDLE;
                end
            end
            EMIT: begin
                if (cls_ok) begin
                    code_nx    = cls_code;
                    confirm_nx = 1'b1;
                end else begin
                    reject_nx = 1'b1;
                    if (err_count != 8'hff) begin
                        err_nx = err_count + 8'd1;
                    end
                end
                cnt_nx   = 8'd0;
                state_nx = WAIT_REL;
            end
            WAIT_REL: begin
                // Any activity restarts the quiet-time count
                if (sv == 4'b0000) begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc == RL) begin
                        cnt_nx   = 8'd0;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = 8'd0;
                end
            end
            default: begin
                cnt_nx   = 8'd0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= 4'b0000;
            cnt       <= 8'd0;
            coin_code <= 2'b00;
            confirm   <= 1'b0;
            reject    <= 1'b0;
            err_count <= 8'd0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            cnt       <= cnt_nx;
            coin_code <= code_nx;
            confirm   <= confirm_nx;
            reject    <= reject_nx;
            err_count <= err_nx;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_intake.sv
// tb_coin_intake: directed stimulus for coin_intake, checked every
// cycle against a sample-stream model plus literal expectations.
module tb_coin_intake;

    localparam int D = 4;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] raw = 4'b0000;
    logic [1:0] coin_code;
    logic       confirm;
    logic       reject;
    logic       busy;
    logic [7:0] err_count;

    coin_intake #(
        .DEBOUNCE(D),
        .RELEASE (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coin5_raw (raw[0]),
        .coin10_raw(raw[1]),
        .coin25_raw(raw[2]),
        .cancel_raw(raw[3]),
        .coin_code (coin_code),
        .confirm   (confirm),
        .reject    (reject),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: raw is seen two edges late; an event is a run of D equal
    // nonzero samples, then one ignored sample, then R quiet samples.
    logic [3:0] m_s1, m_sv, m_pat;
    int         m_phase, m_streak, m_zeros, m_err;
    int         m_code, m_conf, m_rej;

    task automatic model_reset();
        m_s1 = 0; m_sv = 0; m_pat = 0;
        m_phase = 0; m_streak = 0; m_zeros = 0;
        m_err = 0; m_code = 0; m_conf = 0; m_rej = 0;
    endtask

    task automatic model_step();
        logic [3:0] s;
        s = m_sv;
        m_sv = m_s1;
        m_s1 = raw;
        m_conf = 0;
        m_rej = 0;
        if (m_phase == 0) begin
            if (s == 0) m_streak = 0;
            else if (m_streak == 0) begin
                m_pat = s;
                m_streak = 1;
            end else if (s == m_pat) m_streak++;
            else m_streak = 0;
            if (m_streak == D) begin
                m_phase = 1;
                m_streak = 0;
            end
        end else if (m_phase == 1) begin
            if (m_pat[3]) begin
                m_code = 0; m_conf = 1;
            end else if ($countones(m_pat[2:0]) == 1) begin
                m_code = m_pat[2] ? 3 : (m_pat[1] ? 2 : 1);
                m_conf = 1;
            end else begin
                m_rej = 1;
                m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
            end
            m_phase = 2;
            m_zeros = 0;
        end else begin
            m_zeros = (s == 0) ? m_zeros + 1 : 0;
            if (m_zeros == R) m_phase = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    int cyc = 0;
    int n_conf = 0;
    int n_rej = 0;
    int conf_cyc = 0;
    int codes_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("coin_code", coin_code, m_code);
        check("confirm", confirm, m_conf);
        check("reject", reject, m_rej);
        check("busy", busy, (m_phase != 0 || m_streak != 0) ? 1 : 0);
        check("err_count", err_count, m_err);
        check("conf_rej_excl", confirm & reject, 0);
        if (confirm) begin
            n_conf++;
            conf_cyc = cyc;
            codes_q.push_back(int'(coin_code));
        end
        if (reject) n_rej++;
    end

    task automatic drive(input logic [3:0] v, input int n);
        raw = v;
        repeat (n) @(negedge clk);
    endtask

    function automatic int last_code();
        return (codes_q.size() > 0) ? codes_q[$] : 99;
    endfunction

    task automatic check_all_zero(input string nm);
        check({nm, "_code"}, coin_code, 0);
        check({nm, "_confirm"}, confirm, 0);
        check({nm, "_reject"}, reject, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_err"}, err_count, 0);
    endtask

    int b_conf, b_rej, c0;
    int seq_v[6] = '{2, 2, 2, 1, 2, 4};
    int seq_c[6] = '{2, 2, 2, 1, 2, 3};

    initial begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // clean 10c with latency
        c0 = cyc; b_conf = n_conf; b_rej = n_rej;
        drive(4'b0010, 10);
        drive(4'b0000, 12);
        check("t1_confirms", n_conf - b_conf, 1);
        check("t1_code", last_code(), 2);
        check("t1_latency", conf_cyc, c0 + 7);
        check("t1_rejects", n_rej - b_rej, 0);
        check("t1_idle", busy, 0);

        // cancel with coin5
        b_conf = n_conf; b_rej = n_rej;
        drive(4'b1001, 8);
        drive(4'b0000, 12);
        check("t2_confirms", n_conf - b_conf, 1);
        check("t2_code", last_code(), 0);
        check("t2_rejects", n_rej - b_rej, 0);

        // bouncing 25c then held
        b_conf = n_conf;
        drive(4'b0100, 1);
        drive(4'b0000, 1);
        drive(4'b0100, 1);
        drive(4'b0100, 14);
        drive(4'b0000, 12);
        check("t3_confirms", n_conf - b_conf, 1);
        check("t3_code", last_code(), 3);

        // illegal 5c+25c
        b_conf = n_conf; b_rej = n_rej;
        drive(4'b0101, 8);
        drive(4'b0000, 12);
        check("t4_rejects", n_rej - b_rej, 1);
        check("t4_confirms", n_conf - b_conf, 0);
        check("t4_err", err_count, 1);
        check("t4_code_kept", coin_code, 3);

        // back-to-back sequence
        codes_q.delete();
        for (int i = 0; i < 6; i++) begin
            drive(4'(seq_v[i]), 6);
            drive(4'b0000, 6);
        end
        drive(4'b0000, 10);
        check("t5_count", codes_q.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t5_code%0d", i),
                  (i < codes_q.size()) ? codes_q[i] : 99, seq_c[i]);

        // error counter saturation
        b_rej = n_rej;
        repeat (256) begin
            drive(4'b0101, 6);
            drive(4'b0000, 6);
        end
        drive(4'b0000, 10);
        check("t6_rejects", n_rej - b_rej, 256);
        check("t6_err_sat", err_count, 255);

        // async reset mid-SETTLE
        b_conf = n_conf;
        drive(4'b0010, 4);
        check("t7_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t7_rst");
        raw = 4'b0000;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(4'b0000, 10);
        check("t7_no_confirm", n_conf - b_conf, 0);

        // async reset during EMIT
        b_conf = n_conf;
        drive(4'b0001, 6);
        check("t8_busy_before", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("t8_rst");
        raw = 4'b0000;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        drive(4'b0000, 10);
        check("t8_no_confirm", n_conf - b_conf, 0);

        // fresh event after reset
        b_conf = n_conf;
        drive(4'b0100, 8);
        drive(4'b0000, 12);
        check("t9_confirms", n_conf - b_conf, 1);
        check("t9_code", last_code(), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
